// File: rtl/i2c_req_arbiter.sv
// Two-requester round-robin arbiter in front of a single I2C master.
// Latches the winning requester's command, pulses m_start, waits for the
// master's completion (or a timeout) and returns the result with a one-cycle
// done pulse to the owner.
module i2c_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [7:0] rdata,
  output logic       err,
  output logic       tout,
  output logic       busy,
  output logic       m_start,
  output logic [6:0] m_address,
  output logic       m_rw,
  output logic [7:0] m_idata,
  input  logic       m_done,
  input  logic       m_nack,
  input  logic [7:0] m_odata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic        last_q;     // index of the requester served most recently
  logic        win_q;      // index of the requester owning the current transaction
  logic        win_d;
  logic [15:0] cnt_q;
  logic [1:0]  gnt_q;
  logic [1:0]  done_q;
  logic [7:0]  rdata_q;
  logic        err_q;
  logic        tout_q;
  logic        busy_q;
  logic        m_start_q;
  logic [6:0]  m_address_q;
  logic        m_rw_q;
  logic [7:0]  m_idata_q;

  // Winner selection: on contention the requester not served last wins.
  always_comb begin
    win_d = req[1];
    if (req == 2'b11) begin
      win_d = ~last_q;
    end
  end

  // Arbitration / transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      tout_q      <= 1'b0;
      busy_q      <= 1'b0;
      m_start_q   <= 1'b0;
      m_address_q <= '0;
      m_rw_q      <= 1'b0;
      m_idata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            win_q       <= win_d;
            m_address_q <= win_d ? addr1 : addr0;
            m_rw_q      <= win_d ? rw1 : rw0;
            m_idata_q   <= win_d ? wdata1 : wdata0;
            gnt_q       <= win_d ? 2'b10 : 2'b01;
            m_start_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          m_start_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          // A completion in the timeout cycle still counts as a completion.
          if (m_done) begin
            rdata_q <= m_rw_q ? m_odata : 8'h00;
            err_q   <= m_nack;
            tout_q  <= 1'b0;
            gnt_q   <= '0;
            done_q  <= gnt_q;
            state_q <= S_RESP;
          end else if (cnt_q == TO_LAST) begin
            rdata_q <= 8'h00;
            err_q   <= 1'b1;
            tout_q  <= 1'b1;
            gnt_q   <= '0;
            done_q  <= gnt_q;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RESP: begin
          done_q  <= '0;
          last_q  <= win_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign tout      = tout_q;
  assign busy      = busy_q;
  assign m_start   = m_start_q;
  assign m_address = m_address_q;
  assign m_rw      = m_rw_q;
  assign m_idata   = m_idata_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter: a transaction-level model predicts
// the winner, latched command, completion cycle and returned status.
module tb_i2c_req_arbiter;

  localparam int unsigned TO = 8;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [6:0] addr0, addr1;
  logic       rw0, rw1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] gnt, done;
  logic [7:0] rdata;
  logic       err, tout, busy, m_start;
  logic [6:0] m_address;
  logic       m_rw;
  logic [7:0] m_idata;
  logic       m_done, m_nack;
  logic [7:0] m_odata;

  int vectors = 0;
  int miscompares = 0;

  // Model state: who was served last, and the result registers' expected contents.
  logic       last_srv;
  logic [7:0] exp_rdata;
  logic       exp_err, exp_tout;

  i2c_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req),
    .addr0(addr0), .addr1(addr1), .rw0(rw0), .rw1(rw1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err), .tout(tout), .busy(busy),
    .m_start(m_start), .m_address(m_address), .m_rw(m_rw), .m_idata(m_idata),
    .m_done(m_done), .m_nack(m_nack), .m_odata(m_odata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] oh(input logic w);
    return w ? 2'b10 : 2'b01;
  endfunction

  // One complete transaction, called while the DUT sits in IDLE (#1 after an edge).
  // dly = WAIT cycle (0-based) in which m_done is given; dly >= TO means never.
  task automatic do_txn(input logic [1:0] r, input logic [6:0] a0, input logic [6:0] a1,
                        input logic rr0, input logic rr1, input logic [7:0] d0,
                        input logic [7:0] d1, input int unsigned dly, input logic nack,
                        input logic [7:0] od, input logic drop);
    logic w;
    logic [6:0] ea;
    logic erw;
    logic [7:0] ed;
    int n;
    int unsigned term;
    req = r; addr0 = a0; addr1 = a1; rw0 = rr0; rw1 = rr1; wdata0 = d0; wdata1 = d1;
    w   = (r == 2'b11) ? ~last_srv : r[1];
    ea  = w ? a1 : a0;
    erw = w ? rr1 : rr0;
    ed  = w ? d1 : d0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n++;
      if (m_start === 1'b1) break;
    end
    vectors++;
    if (m_start !== 1'b1 || n != 1) begin
      miscompares++;
      $display("FAIL start_latency: m_start=%b after %0d edges, required 1 after 1", m_start, n);
      return;
    end
    vectors++;
    if ({gnt, busy, done, m_address, m_rw, m_idata} !== {oh(w), 1'b1, 2'b00, ea, erw, ed}) begin
      miscompares++;
      $display("FAIL issue: gnt=%b busy=%b done=%b addr=%h rw=%b idata=%h, required gnt=%b busy=1 done=00 addr=%h rw=%b idata=%h",
               gnt, busy, done, m_address, m_rw, m_idata, oh(w), ea, erw, ed);
    end
    addr0 = 7'($urandom); addr1 = 7'($urandom); rw0 = 1'($urandom); rw1 = 1'($urandom);
    wdata0 = 8'($urandom); wdata1 = 8'($urandom);
    if (drop) req = 2'b00;
    term = (dly < TO) ? dly : TO - 1;
    for (int unsigned j = 0; j <= term; j++) begin
      @(posedge clk); #1;
      vectors++;
      if ({m_start, gnt, done, busy, m_address, m_idata} !== {1'b0, oh(w), 2'b00, 1'b1, ea, ed}) begin
        miscompares++;
        $display("FAIL wait%0d: m_start=%b gnt=%b done=%b busy=%b addr=%h idata=%h, required 0 %b 00 1 %h %h",
                 j, m_start, gnt, done, busy, m_address, m_idata, oh(w), ea, ed);
      end
      m_odata = 8'($urandom);
      m_nack  = 1'($urandom);
      if (j == dly) begin
        m_done = 1'b1; m_nack = nack; m_odata = od;
      end
    end
    @(posedge clk); #1;
    m_done = 1'b0;
    if (dly < TO) begin
      exp_rdata = erw ? od : 8'h00; exp_err = nack; exp_tout = 1'b0;
    end else begin
      exp_rdata = 8'h00; exp_err = 1'b1; exp_tout = 1'b1;
    end
    vectors++;
    if ({done, gnt, busy, rdata, err, tout} !== {oh(w), 2'b00, 1'b1, exp_rdata, exp_err, exp_tout}) begin
      miscompares++;
      $display("FAIL resp: done=%b gnt=%b busy=%b rdata=%h err=%b tout=%b, required %b 00 1 %h %b %b",
               done, gnt, busy, rdata, err, tout, oh(w), exp_rdata, exp_err, exp_tout);
    end
    last_srv = w;
    @(posedge clk); #1;
    vectors++;
    if ({done, gnt, m_start, busy, rdata, err, tout} !== {2'b00, 2'b00, 1'b0, 1'b0, exp_rdata, exp_err, exp_tout}) begin
      miscompares++;
      $display("FAIL idle_after: done=%b gnt=%b m_start=%b busy=%b rdata=%h err=%b tout=%b, required 00 00 0 0 %h %b %b",
               done, gnt, m_start, busy, rdata, err, tout, exp_rdata, exp_err, exp_tout);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 2'b00; m_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({gnt, done, m_start, m_rw, err, tout, busy, m_address, m_idata, rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset: gnt=%b done=%b m_start=%b m_rw=%b err=%b tout=%b busy=%b addr=%h idata=%h rdata=%h, required all zero",
               gnt, done, m_start, m_rw, err, tout, busy, m_address, m_idata, rdata);
    end
    reset = 1'b0;
    last_srv = 1'b1; exp_rdata = 8'h00; exp_err = 1'b0; exp_tout = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({busy, m_start, gnt} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b m_start=%b gnt=%b, required 0 0 00", busy, m_start, gnt);
    end
  endtask

  task automatic test_back_to_back;
    do_txn(2'b11, 7'h11, 7'h22, 1'b0, 1'b1, 8'h01, 8'h02, 1, 1'b0, 8'hC3, 1'b0);
    do_txn(2'b11, 7'h33, 7'h44, 1'b1, 1'b0, 8'h03, 8'h04, 0, 1'b1, 8'h99, 1'b0);
    do_txn(2'b11, 7'h55, 7'h66, 1'b1, 1'b1, 8'h05, 8'h06, 3, 1'b0, 8'h7E, 1'b0);
  endtask

  task automatic test_basic_write;
    do_txn(2'b01, 7'h55, 7'h2A, 1'b0, 1'b1, 8'hA5, 8'h5A, 4, 1'b0, 8'hEE, 1'b0);
  endtask

  task automatic test_read_nack;
    do_txn(2'b10, 7'h10, 7'h68, 1'b0, 1'b1, 8'h00, 8'h00, 2, 1'b1, 8'h3C, 1'b1);
  endtask

  task automatic test_timeout;
    do_txn(2'b01, 7'h21, 7'h12, 1'b1, 1'b0, 8'h0F, 8'hF0, 100, 1'b0, 8'hAB, 1'b0);
    do_txn(2'b10, 7'h31, 7'h13, 1'b0, 1'b1, 8'h1F, 8'hF1, TO - 1, 1'b0, 8'h5A, 1'b0);
  endtask

  task automatic test_ignore_mdone;
    req = 2'b00; m_done = 1'b1; m_nack = 1'b1; m_odata = 8'hFF;
    @(posedge clk); #1;
    m_done = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({done, busy, gnt, m_start, rdata, err, tout} !== {2'b00, 1'b0, 2'b00, 1'b0, exp_rdata, exp_err, exp_tout}) begin
      miscompares++;
      $display("FAIL ignore_mdone: done=%b busy=%b gnt=%b m_start=%b rdata=%h err=%b tout=%b, required 00 0 00 0 %h %b %b",
               done, busy, gnt, m_start, rdata, err, tout, exp_rdata, exp_err, exp_tout);
    end
  endtask

  task automatic test_reset_mid_wait;
    req = 2'b10; addr1 = 7'h4D; rw1 = 1'b0; wdata1 = 8'h77;
    @(posedge clk); #1;
    vectors++;
    if (m_start !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_start: m_start=%b, required 1", m_start);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; req = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    last_srv = 1'b1; exp_rdata = 8'h00; exp_err = 1'b0; exp_tout = 1'b0;
    vectors++;
    if ({gnt, done, m_start, busy, err, tout, m_address, m_idata, rdata} !== '0) begin
      miscompares++;
      $display("FAIL abort_reset: gnt=%b done=%b m_start=%b busy=%b err=%b tout=%b addr=%h idata=%h rdata=%h, required all zero",
               gnt, done, m_start, busy, err, tout, m_address, m_idata, rdata);
    end
    m_done = 1'b1;
    @(posedge clk); #1;
    m_done = 1'b0;
    vectors++;
    if ({done, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_nodone: done=%b busy=%b, required 00 0", done, busy);
    end
    do_txn(2'b01, 7'h0A, 7'h0B, 1'b1, 1'b0, 8'h11, 8'h22, 5, 1'b0, 8'h66, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      do_txn(2'($urandom_range(1, 3)), 7'($urandom), 7'($urandom), 1'($urandom), 1'($urandom),
             8'($urandom), 8'($urandom), $urandom_range(0, 9), 1'($urandom), 8'($urandom),
             $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; addr0 = '0; addr1 = '0; rw0 = 1'b0; rw1 = 1'b0;
    wdata0 = '0; wdata1 = '0; m_done = 1'b0; m_nack = 1'b0; m_odata = '0;
    last_srv = 1'b1; exp_rdata = 8'h00; exp_err = 1'b0; exp_tout = 1'b0;
    test_reset;
    test_back_to_back;
    test_basic_write;
    test_read_nack;
    test_timeout;
    test_ignore_mdone;
    test_reset_mid_wait;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, is the maximum number of WAIT-state cycles allowed before a transaction is aborted; legal range 2..65535.
REQ-002 clk  input  1  is the single clock; all logic is rising-edge clocked.
REQ-003 reset  input  1  is a synchronous, active-high reset.
REQ-004 req  input  2  is the per-requester level request; bit i belongs to requester i.
REQ-005 addr0/addr1  input  7  carry each requester's 7-bit target address.
REQ-006 rw0/rw1  input  1  select each requester's direction; 1 = read, 0 = write.
REQ-007 wdata0/wdata1  input  8  carry each requester's write byte.
REQ-008 gnt  output  2  is one-hot or zero and marks the requester currently owning the master.
REQ-009 done  output  2  is a one-cycle completion pulse to the owning requester.
REQ-010 rdata  output  8  returns the read byte, valid while done is nonzero.
REQ-011 err  output  1  flags NACK or timeout, valid while done is nonzero.
REQ-012 tout  output  1  flags timeout, valid while done is nonzero.
REQ-013 busy  output  1  is high in every state except IDLE.
REQ-014 m_start  output  1  is the one-cycle start pulse to the I2C master.
REQ-015 m_address  output  7, m_rw  output  1, m_idata  output  8  are the latched command fields driven to the master.
REQ-016 m_done  input  1  is the master's one-cycle transaction-complete pulse.
REQ-017 m_nack  input  1  is the master's NACK status, sampled with m_done.
REQ-018 m_odata  input  8  is the master's read byte, sampled with m_done.

Function
REQ-019 The FSM SHALL have four states, IDLE, ISSUE, WAIT and RESP, encoded in one state register.
REQ-020 In IDLE with req nonzero, the block SHALL select a winner, latch that requester's addr, rw and wdata into m_address, m_rw and m_idata, and enter ISSUE.
REQ-021 Arbitration SHALL be round-robin: when both bits of req are high, the winner is the requester not served last; after reset requester 0 has priority.
REQ-022 In ISSUE, gnt[winner] and m_start SHALL both be high; m_start SHALL be high for exactly one cycle, and the next state is WAIT.
REQ-023 gnt[winner] SHALL stay high from ISSUE through WAIT and go low on entry to RESP.
REQ-024 In WAIT, a 16-bit counter starting at 0 SHALL increment every cycle.
REQ-025 In WAIT, if m_done=1, the block SHALL capture rdata (m_odata when m_rw=1, 8'h00 otherwise) and err=m_nack, set tout=0, and enter RESP.
REQ-026 In WAIT, if m_done=0 and the counter equals TIMEOUT_CYCLES-1, the block SHALL set err=1, tout=1 and rdata=8'h00, and enter RESP.
REQ-027 If m_done and the timeout condition occur in the same cycle, m_done SHALL take precedence.
REQ-028 In RESP, done[winner] SHALL be high for exactly one cycle, the round-robin pointer SHALL be updated to the winner, and the next state is IDLE.
REQ-029 rdata, err and tout SHALL hold their values until the next RESP.
REQ-030 m_done outside WAIT SHALL be ignored.
REQ-031 Deasserting req mid-transaction SHALL NOT abort the transaction; done still pulses.
REQ-032 Changes on addr, rw and wdata after the latch SHALL NOT affect m_address, m_rw or m_idata.
REQ-033 Latency: req sampled high at IDLE cycle T gives gnt and m_start at T+1; m_done at cycle D gives done at D+1; minimum spacing between start pulses is 4 cycles.

Reset
REQ-034 With reset high, state SHALL be IDLE, the pointer SHALL favour requester 0, the counter SHALL be 0, and gnt, done, m_start, m_rw, err, tout and busy SHALL be 0, with m_address, m_idata and rdata all zero.
REQ-035 Reset asserted in any state SHALL abandon the transaction on the next edge, with no done pulse.

Verification
REQ-036 req=01, addr0=7'h55, rw0=0, wdata0=8'hA5; m_done with m_nack=0 five cycles after m_start -> one m_start with m_address=7'h55 and m_idata=8'hA5, done=01 with err=0.
REQ-037 req=11 held, after reset -> requester 0 served first, then requester 1, then requester 0; each done is followed by a new m_start 2 cycles later.
REQ-038 Read: rw1=1 with m_odata=8'h3C and m_nack=1 at m_done -> done=10, rdata=8'h3C, err=1, tout=0.
REQ-039 TIMEOUT_CYCLES=8 with no m_done -> done after the counter reaches 7 in WAIT, with err=1, tout=1 and rdata=8'h00; m_done in the same cycle as the timeout -> tout=0.
REQ-040 Reset pulsed during WAIT, then req=01 -> no done pulse for the aborted transaction, and a fresh m_start one cycle after IDLE samples req.
